// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, captures {pc, instr} into a small
// circular prefetch queue and hands entries to decode. Optional: FETCH_MISALIGN_TRAP_EN.
module fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        out_misalign_o,
`endif
  output logic [31:0] out_pc_plus4_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_mem    [QUEUE_DEPTH];
  logic [31:0]      instr_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic [31:0]      push_instr;
  logic [31:0]      redirect_target;

  assign pop = out_valid_o && out_ready_i;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_mem [QUEUE_DEPTH];
  logic halted;
  logic fetch_misaligned;

  assign fetch_misaligned = (fetch_pc[1:0] != 2'b00);
  assign push             = !redirect_i && (count < DEPTH_C || pop) && !halted;
  assign push_instr       = fetch_misaligned ? NOP_INSTR : instr_i;
  assign redirect_target  = redirect_pc_i;

  always_ff @(posedge clk) begin
    if (push) misalign_mem[wr_ptr] <= fetch_misaligned;
  end

  // A misaligned fetch emits a single trap marker, then fetch stalls until redirect/reset.
  always_ff @(posedge clk) begin
    if (rst || redirect_i) halted <= 1'b0;
    else if (push && fetch_misaligned) halted <= 1'b1;
  end

  assign out_misalign_o = out_valid_o && misalign_mem[rd_ptr];
`else
  logic unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc_i[1:0];
  assign push            = !redirect_i && (count < DEPTH_C || pop);
  assign push_instr      = instr_i;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
`endif

  // Storage carries no reset; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
`ifdef FETCH_MISALIGN_TRAP_EN
        if (!fetch_misaligned) fetch_pc <= fetch_pc + 32'd4;
`else
        fetch_pc <= fetch_pc + 32'd4;
`endif
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign pc_o           = fetch_pc;
  assign out_valid_o    = (count != '0);
  assign out_pc_o       = out_valid_o ? pc_mem[rd_ptr] : 32'h0;
  assign out_instr_o    = out_valid_o ? instr_mem[rd_ptr] : NOP_INSTR;
  assign out_pc_plus4_o = out_pc_o + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus hand-written
// sequences for reset/redirect priority and the misalign trap.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_plus4_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        out_misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign instr_i = mem_word(pc_o);

  fetch_queue #(.RESET_PC(32'h0), .QUEUE_DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .pc_o(pc_o),
    .instr_i(instr_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o),
    .out_instr_o(out_instr_o),
`ifdef FETCH_MISALIGN_TRAP_EN
    .out_misalign_o(out_misalign_o),
`endif
    .out_pc_plus4_o(out_pc_plus4_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Compares every head output against the expected head state.
  task automatic check_head(input string tag, input logic exp_valid, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr, input logic [31:0] exp_fetch);
    check({tag, ".valid"}, {31'b0, out_valid_o}, {31'b0, exp_valid});
    check({tag, ".out_pc"}, out_pc_o, exp_valid ? exp_pc : 32'h0);
    check({tag, ".instr"}, out_instr_o, exp_valid ? exp_instr : NOP);
    check({tag, ".plus4"}, out_pc_plus4_o, (exp_valid ? exp_pc : 32'h0) + 32'd4);
    check({tag, ".pc_o"}, pc_o, exp_fetch);
  endtask

  task automatic drive(input logic r, input logic red, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst = r;
    redirect_i = red;
    redirect_pc_i = rpc;
    out_ready_i = rdy;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        red;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] ODD_TGT = 32'h0000_0200;
`else
  localparam logic [31:0] ODD_TGT = 32'h0000_0203;
`endif

  initial begin
    // {rst, redirect, redirect_pc, ready} -> {valid, head pc, fetch pc} before the edge
    vecs[0]  = '{0, 0, 32'h0, 1, 0, 32'h0, 32'h0};
    vecs[1]  = '{0, 0, 32'h0, 1, 1, 32'h0, 32'h4};
    vecs[2]  = '{0, 0, 32'h0, 1, 1, 32'h4, 32'h8};
    vecs[3]  = '{0, 0, 32'h0, 1, 1, 32'h8, 32'hC};
    vecs[4]  = '{0, 0, 32'h0, 1, 1, 32'hC, 32'h10};
    vecs[5]  = '{1, 0, 32'h0, 0, 1, 32'h10, 32'h14};
    vecs[6]  = '{0, 0, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[7]  = '{0, 0, 32'h0, 0, 1, 32'h0, 32'h4};
    vecs[8]  = '{0, 0, 32'h0, 0, 1, 32'h0, 32'h8};
    vecs[9]  = '{0, 0, 32'h0, 0, 1, 32'h0, 32'h8};
    vecs[10] = '{0, 0, 32'h0, 1, 1, 32'h0, 32'h8};
    vecs[11] = '{0, 0, 32'h0, 1, 1, 32'h4, 32'hC};
    vecs[12] = '{0, 0, 32'h0, 1, 1, 32'h8, 32'h10};
    vecs[13] = '{0, 0, 32'h0, 1, 1, 32'hC, 32'h14};
    vecs[14] = '{0, 0, 32'h0, 0, 1, 32'h10, 32'h18};
    vecs[15] = '{0, 1, 32'h100, 0, 1, 32'h10, 32'h18};
    vecs[16] = '{0, 0, 32'h0, 0, 0, 32'h0, 32'h100};
    vecs[17] = '{0, 0, 32'h0, 1, 1, 32'h100, 32'h104};
    vecs[18] = '{0, 0, 32'h0, 1, 1, 32'h104, 32'h108};
    vecs[19] = '{0, 1, 32'hFFFF_FFFC, 1, 1, 32'h108, 32'h10C};
    vecs[20] = '{0, 0, 32'h0, 1, 0, 32'h0, 32'hFFFF_FFFC};
    vecs[21] = '{0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h0};
    vecs[22] = '{0, 0, 32'h0, 1, 1, 32'h0, 32'h4};
    vecs[23] = '{0, 1, ODD_TGT, 1, 1, 32'h4, 32'h8};
    vecs[24] = '{0, 1, 32'h300, 1, 0, 32'h0, 32'h200};
    vecs[25] = '{0, 0, 32'h0, 1, 0, 32'h0, 32'h300};
    vecs[26] = '{0, 0, 32'h0, 1, 1, 32'h300, 32'h304};
    vecs[27] = '{0, 0, 32'h0, 0, 1, 32'h304, 32'h308};
    vecs[28] = '{1, 0, 32'h0, 0, 1, 32'h304, 32'h30C};
    vecs[29] = '{0, 0, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[30] = '{0, 0, 32'h0, 1, 1, 32'h0, 32'h4};
    vecs[31] = '{0, 0, 32'h0, 1, 1, 32'h4, 32'h8};

    rst = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].red, vecs[i].rpc, vecs[i].rdy);
      check_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                 mem_word(vecs[i].exp_pc), vecs[i].exp_fetch);
`ifdef FETCH_MISALIGN_TRAP_EN
      check($sformatf("vec%0d.misalign", i), {31'b0, out_misalign_o}, 32'h0);
`endif
    end

    // Reset wins over a simultaneous redirect; state: head 0x8, fetch 0xC.
    drive(1, 1, 32'h500, 1);
    check_head("rstred.pre", 1, 32'h8, mem_word(32'h8), 32'hC);
    drive(0, 0, 32'h0, 1);
    check_head("rstred.post", 0, 32'h0, NOP, 32'h0);
    drive(0, 0, 32'h0, 1);
    check_head("rstred.head", 1, 32'h0, mem_word(32'h0), 32'h4);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect: one trap entry, then fetch stalls.
    drive(0, 1, 32'h102, 1);
    drive(0, 0, 32'h0, 1);
    check_head("mis.bubble", 0, 32'h0, NOP, 32'h102);
    drive(0, 0, 32'h0, 1);
    check_head("mis.head", 1, 32'h102, NOP, 32'h102);
    check("mis.flag", {31'b0, out_misalign_o}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 32'h0, 1);
      check_head($sformatf("mis.halt%0d", k), 0, 32'h0, NOP, 32'h102);
      check($sformatf("mis.halt%0d.flag", k), {31'b0, out_misalign_o}, 32'h0);
    end
    drive(0, 1, 32'h200, 1);
    drive(0, 0, 32'h0, 1);
    check_head("mis.resume0", 0, 32'h0, NOP, 32'h200);
    drive(0, 0, 32'h0, 1);
    check_head("mis.resume1", 1, 32'h200, mem_word(32'h200), 32'h204);
    check("mis.resume.flag", {31'b0, out_misalign_o}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch front end, directly upstream of the byte-addressed, combinational-read instruction memory. Owns the fetch PC and drives it to memory. Captures the returned word, together with its PC, into a small prefetch queue. Presents queue entries to decode with a valid/ready handshake and handles control-flow redirects by flushing the queue.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
QUEUE_DEPTH, 2, number of queue entries; power of two, >= 2
NOP_INSTR, 32'h0000_0013, value driven on out_instr_o while the queue is empty (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
pc_o  out  32  fetch address to instruction memory PC input
instr_i  in  32  instruction word returned combinationally for pc_o
redirect_i  in  1  redirect request (branch/jump taken)
redirect_pc_i  in  32  redirect target
out_valid_o  out  1  queue head valid
out_ready_i  in  1  decode accepts head
out_pc_o  out  32  PC of head entry
out_instr_o  out  32  instruction of head entry
out_pc_plus4_o  out  32  out_pc_o + 4, modulo 2^32

Behaviour:
- State: fetch_pc (32b), circular storage of QUEUE_DEPTH entries {pc, instr}, wr_ptr/rd_ptr (clog2(QUEUE_DEPTH) bits, wrap naturally), count (clog2(QUEUE_DEPTH)+1 bits).
- pc_o = fetch_pc, combinational from the register. instr_i is sampled in the same cycle.
- pop = out_valid_o & out_ready_i.
- push = !redirect_i & (count < QUEUE_DEPTH | pop).
- On push: write {fetch_pc, instr_i} at wr_ptr; fetch_pc <= fetch_pc + 4 (0xFFFF_FFFC wraps to 0x0).
- Full and pop in the same cycle: push still occurs. Count unchanged; no bubble.
- Empty: no pop is possible. Push occurs; the entry becomes visible next cycle.
- Latency: a word fetched in cycle N appears at the head no earlier than cycle N+1.
- Throughput: 1 entry/cycle sustained with out_ready_i = 1.
- Outputs are combinational from the head entry: out_valid_o = (count != 0).
- When empty: out_pc_o = 0, out_pc_plus4_o = 4, out_instr_o = NOP_INSTR.
- Redirect (redirect_i = 1, rst = 0):
  - count <= 0, wr_ptr <= rd_ptr <= 0, fetch_pc <= redirect_pc_i.
  - No push that cycle.
  - A head handshake in the same cycle counts as consumed by decode; every other entry is discarded.
- The first post-redirect entry (pc = target) is valid one cycle after the cycle following redirect, i.e. a 1-cycle bubble minimum.
- Back-to-back redirects: the last one wins; fetch does not resume until redirect_i deasserts.
- Reset has priority over redirect and pop: fetch_pc <= RESET_PC, count/pointers <= 0.
- Reset effects: out_valid_o = 0 in the cycle after rst is sampled high. Storage contents need no reset.
- Reset mid-stream: all queued entries are dropped with no partial state.
- No assertion on redirect_pc_i alignment unless the optional feature is compiled in. Without it, bits [1:0] are forced to 0 when loaded.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - Redirect target bits [1:0] are kept verbatim.
  - Port out_misalign_o (out, 1) is added and carried per entry.
  - When fetch_pc[1:0] != 0, one entry is pushed with misalign = 1 and instr = NOP_INSTR, then pushes stop (fetch_pc held) until the next redirect or reset.
  - out_misalign_o = 0 when empty.
- Undefined: no out_misalign_o port; redirect_pc_i[1:0] forced to 2'b00; fetch never halts.

Test Plan:
1. Release reset with RESET_PC = 0, out_ready_i = 1 constant, memory word = address pattern -> out_valid_o rises 1 cycle after the first unreset edge; out_pc_o = 0,4,8,12 on consecutive cycles; out_instr_o matches memory; out_pc_plus4_o = out_pc_o + 4.
2. out_ready_i = 0 from reset -> queue fills with pc 0,4; pc_o holds 8; out_pc_o stays 0. Then raise out_ready_i -> heads 0,4,8,12 on consecutive cycles, no bubble.
3. Queue full (pc 0,4), pulse redirect_i with redirect_pc_i = 0x100 -> next cycle out_valid_o = 0, out_instr_o = 0x0000_0013, pc_o = 0x100; following cycle out_pc_o = 0x100, then 0x104.
4. Redirect to 0xFFFF_FFFC with out_ready_i = 1 -> heads 0xFFFF_FFFC then 0x0000_0000; out_pc_plus4_o = 0x0 for the first.
5. Queue full plus rst asserted for one cycle mid-stream -> next cycle out_valid_o = 0, pc_o = RESET_PC; first head afterwards has pc = RESET_PC; no stale entry reappears.
6. With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> one head with out_pc_o = 0x102, out_misalign_o = 1, out_instr_o = 0x13; then out_valid_o = 0 indefinitely. Redirect to 0x200 -> head 0x200, out_misalign_o = 0.
